// File: rtl/map_read_arbiter_pkg.sv
// Shared types for the map BRAM read arbiter: map address/cell types, requester
// id and the per-read tag that travels alongside the BRAM latency.
package map_arb_pkg;

  localparam int MAP_N          = 24;
  localparam int MAP_DATA_WIDTH = 4;
  localparam int MAX_REQ        = 8;

  function automatic int map_addr_w(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

  localparam int MAP_ADDR_W = map_addr_w(MAP_N);
  // Id field is sized for the largest supported requester count so one tag
  // layout serves every NUM_REQ configuration.
  localparam int REQ_ID_W   = $clog2(MAX_REQ);

  typedef logic [MAP_ADDR_W-1:0]     map_addr_t;
  typedef logic [MAP_DATA_WIDTH-1:0] map_cell_t;
  typedef logic [REQ_ID_W-1:0]       req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
    logic    oob;
  } rd_tag_t;

endpackage

// File: rtl/map_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after
// last_grant+1, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [ID_W-1:0]    last_grant,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  always_comb begin
    logic [ID_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    // k = NUM_REQ lands back on last_grant, so it is considered last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/map_read_arbiter.sv
// Round-robin arbiter sharing one registered-output map BRAM between several
// DDA FSMs; each read is tagged with its owner and returned as a one-cycle pulse.
module map_read_arbiter
  import map_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 2,
  parameter  int N            = 24,
  parameter  int DATA_WIDTH   = 4,
  parameter  int READ_LATENCY = 2,
  localparam int ADDR_W       = map_addr_w(N)
) (
  input  logic                           pixel_clk_in,
  input  logic                           rst_n_in,
  input  logic [NUM_REQ-1:0]             req_in,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_in,
  output logic [NUM_REQ-1:0]             data_valid_out,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic [ADDR_W-1:0]              bram_addr_out,
  input  logic [DATA_WIDTH-1:0]          bram_data_in,
  output logic [NUM_REQ-1:0]             grant_out,
  output logic                           busy_out
);

  localparam int              ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(N * N);

  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] eligible;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_found;
  logic               pick_oob;
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] tail_oh;
  rd_tag_t            tag_pipe [READ_LATENCY:0];

  // A requester with a read in flight is ignored until its pulse has gone.
  assign eligible = req_in & ~pending;

  rr_pick #(
    .NUM_REQ    (NUM_REQ),
    .ID_W       (ID_W)
  ) u_pick (
    .eligible   (eligible),
    .last_grant (last_grant),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  assign pick_oob = {1'b0, addr_in[pick_idx]} >= DEPTH;
  assign grant_oh = NUM_REQ'(1) << pick_idx;
  assign tail_oh  = NUM_REQ'(1) << tag_pipe[READ_LATENCY].id;
  assign busy_out = |pending;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      grant_out      <= '0;
      bram_addr_out  <= '0;
      pending        <= '0;
      last_grant     <= ID_W'(NUM_REQ - 1);
      data_valid_out <= '0;
      data_out       <= '0;
      for (int s = 0; s <= READ_LATENCY; s++) tag_pipe[s] <= '0;
    end else begin
      tag_pipe[0] <= '{valid: pick_found, id: req_id_t'(pick_idx), oob: pick_oob};
      for (int s = 1; s <= READ_LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];

      grant_out <= pick_found ? grant_oh : '0;
      if (pick_found) begin
        bram_addr_out <= addr_in[pick_idx];
        last_grant    <= pick_idx;
      end

      // Clearing on the pulse edge and setting on grant never hit the same
      // bit: a pending requester is not eligible.
      pending <= (pending & ~data_valid_out) | (pick_found ? grant_oh : '0);

      // Tail tag lines up with bram_data_in for the same read.
      if (tag_pipe[READ_LATENCY].valid) begin
        data_valid_out <= tail_oh;
        data_out       <= tag_pipe[READ_LATENCY].oob ? '0 : bram_data_in;
      end else begin
        data_valid_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_map_read_arbiter.sv
// Bench for map_read_arbiter: a cycle-indexed reference model of grants and returns,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_map_read_arbiter;

  localparam int NR    = 2;
  localparam int N     = 24;
  localparam int DW    = 4;
  localparam int RL    = 2;
  localparam int AW    = 10;
  localparam int DEPTH = N * N;
  localparam int MAXC  = 2048;

  logic                   pixel_clk_in = 1'b0;
  logic                   rst_n_in;
  logic [NR-1:0]          req_in;
  logic [NR-1:0][AW-1:0]  addr_in;
  logic [NR-1:0]          data_valid_out;
  logic [DW-1:0]          data_out;
  logic [AW-1:0]          bram_addr_out;
  logic [DW-1:0]          bram_data_in;
  logic [NR-1:0]          grant_out;
  logic                   busy_out;

  map_read_arbiter #(
    .NUM_REQ(NR), .N(N), .DATA_WIDTH(DW), .READ_LATENCY(RL)
  ) dut (
    .pixel_clk_in   (pixel_clk_in),
    .rst_n_in       (rst_n_in),
    .req_in         (req_in),
    .addr_in        (addr_in),
    .data_valid_out (data_valid_out),
    .data_out       (data_out),
    .bram_addr_out  (bram_addr_out),
    .bram_data_in   (bram_data_in),
    .grant_out      (grant_out),
    .busy_out       (busy_out)
  );

  always #5 pixel_clk_in = ~pixel_clk_in;

  // Map BRAM: registered output, two cycles address to data.
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] rd_q;
  always @(posedge pixel_clk_in) begin
    rd_q         <= mem[bram_addr_out];
    bram_data_in <= rd_q;
  end

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [NR-1:0] drop_mask;

  logic [NR-1:0] exp_grant [MAXC];
  logic [NR-1:0] exp_dv    [MAXC];
  logic [AW-1:0] exp_addr  [MAXC];
  logic [DW-1:0] exp_data  [MAXC];
  logic [NR-1:0] log_grant [MAXC];
  logic [NR-1:0] log_dv    [MAXC];
  logic [AW-1:0] log_addr  [MAXC];
  logic [DW-1:0] log_data  [MAXC];
  logic          log_busy  [MAXC];
  int issue [NR];
  int done  [NR];
  int m_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // A read is outstanding from the cycle after its grant through its pulse cycle.
  function automatic bit pend(input int i, input int c);
    return (issue[i] < c) && (c <= done[i]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < MAXC; c++) begin
      exp_grant[c] = '0; exp_dv[c] = '0; exp_addr[c] = '0; exp_data[c] = '0;
      log_grant[c] = '0; log_dv[c] = '0; log_addr[c] = '0; log_data[c] = '0;
      log_busy[c]  = 1'b0;
    end
    for (int i = 0; i < NR; i++) begin issue[i] = -100; done[i] = -100; end
    m_last = NR - 1;
  endtask

  // Decide what the edge ending cycle cyc does, from the request rules.
  task automatic model_step();
    bit found;
    int g, i, a;
    found = 1'b0; g = 0;
    for (int k = 1; k <= NR; k++) begin
      i = (m_last + k) % NR;
      if (!found && req_in[i] && !pend(i, cyc)) begin found = 1'b1; g = i; end
    end
    exp_grant[cyc+1] = found ? NR'(1) << g : '0;
    exp_addr[cyc+1]  = found ? addr_in[g] : exp_addr[cyc];
    if (found) begin
      a = int'(addr_in[g]);
      exp_dv[cyc+2+RL]   = NR'(1) << g;
      exp_data[cyc+2+RL] = (a >= DEPTH) ? '0 : mem[a];
      issue[g] = cyc;
      done[g]  = cyc + 2 + RL;
      m_last   = g;
    end
  endtask

  task automatic check_and_log();
    bit eb;
    eb = 1'b0;
    for (int i = 0; i < NR; i++) eb |= pend(i, cyc);
    log_grant[cyc] = grant_out; log_dv[cyc] = data_valid_out;
    log_addr[cyc]  = bram_addr_out; log_data[cyc] = data_out; log_busy[cyc] = busy_out;
    chk("grant", 32'(grant_out), 32'(exp_grant[cyc]));
    chk("bram_addr", 32'(bram_addr_out), 32'(exp_addr[cyc]));
    chk("data_valid", 32'(data_valid_out), 32'(exp_dv[cyc]));
    chk("busy", 32'(busy_out), 32'(eb));
    if (exp_dv[cyc] != '0) chk("data", 32'(data_out), 32'(exp_data[cyc]));
  endtask

  // Called at a negedge with inputs set; ends at the next negedge after checking.
  task automatic tick();
    model_step();
    @(posedge pixel_clk_in);
    cyc++;
    @(negedge pixel_clk_in);
    check_and_log();
    for (int i = 0; i < NR; i++)
      if (drop_mask[i] && req_in[i] && exp_dv[cyc][i]) req_in[i] = 1'b0;
  endtask

  task automatic drain(input int n);
    req_in = '0;
    repeat (n) tick();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(7, 0) == 0) return AW'($urandom_range(1023, DEPTH));
    return AW'($urandom_range(DEPTH - 1, 0));
  endfunction

  task automatic contention();
    int b;
    b = cyc;
    drop_mask = '1;
    req_in = 2'b11; addr_in[0] = 10'd5; addr_in[1] = 10'd6;
    repeat (8) tick();
    chk("cont_grant0", 32'(log_grant[b+1]), 32'd1);
    chk("cont_grant1", 32'(log_grant[b+2]), 32'd2);
    chk("cont_addr0", 32'(log_addr[b+1]), 32'd5);
    chk("cont_addr1", 32'(log_addr[b+2]), 32'd6);
    chk("cont_dv0", 32'(log_dv[b+4]), 32'd1);
    chk("cont_data0", 32'(log_data[b+4]), 32'd1);
    chk("cont_dv1", 32'(log_dv[b+5]), 32'd2);
    chk("cont_data1", 32'(log_data[b+5]), 32'd2);
  endtask

  initial begin
    int b, c0, c1, anydv;
    for (int i = 0; i < 1024; i++)
      mem[i] = (i >= DEPTH) ? 4'hF : DW'($urandom_range(15, 0));
    mem[25] = 4'd3; mem[5] = 4'd1; mem[6] = 4'd2; mem[100] = 4'd9;

    rst_n_in = 1'b0; req_in = '0; addr_in = '0; drop_mask = '1;
    cyc = 0;
    repeat (2) @(posedge pixel_clk_in);
    @(negedge pixel_clk_in);
    chk("rst_dv", 32'(data_valid_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_grant", 32'(grant_out), 32'd0);
    chk("rst_addr", 32'(bram_addr_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    rst_n_in = 1'b1;
    model_reset();
    check_and_log();

    contention();
    drain(4);

    // single request
    b = cyc; drop_mask = '1;
    req_in = 2'b01; addr_in[0] = 10'd25;
    repeat (8) tick();
    chk("single_addr", 32'(log_addr[b+1]), 32'd25);
    chk("single_grant", 32'(log_grant[b+1]), 32'd1);
    chk("single_dv_early", 32'(log_dv[b+3]), 32'd0);
    chk("single_dv", 32'(log_dv[b+4]), 32'd1);
    chk("single_data", 32'(log_data[b+4]), 32'd3);
    chk("single_dv_late", 32'(log_dv[b+5]), 32'd0);
    chk("single_busy_pre", 32'(log_busy[b]), 32'd0);
    for (int k = 1; k <= 4; k++) chk("single_busy", 32'(log_busy[b+k]), 32'd1);
    chk("single_busy_post", 32'(log_busy[b+5]), 32'd0);

    // request held through the valid cycle
    b = cyc; drop_mask = '0;
    req_in = 2'b01; addr_in[0] = 10'd100;
    repeat (12) tick();
    chk("hold_grant1", 32'(log_grant[b+1]), 32'd1);
    chk("hold_nogrant", 32'(log_grant[b+5]), 32'd0);
    chk("hold_grant2", 32'(log_grant[b+6]), 32'd1);
    chk("hold_dv2", 32'(log_dv[b+9]), 32'd1);
    chk("hold_data2", 32'(log_data[b+9]), 32'd9);
    drain(8);

    // out-of-range address
    b = cyc; drop_mask = '1;
    req_in = 2'b01; addr_in[0] = 10'd576;
    repeat (8) tick();
    chk("oob_dv", 32'(log_dv[b+4]), 32'd1);
    chk("oob_data", 32'(log_data[b+4]), 32'd0);

    // reset while a read is in flight
    drop_mask = '1;
    req_in = 2'b01; addr_in[0] = 10'd25;
    tick(); tick();
    rst_n_in = 1'b0; req_in = '0;
    #1;
    chk("midrst_dv", 32'(data_valid_out), 32'd0);
    chk("midrst_data", 32'(data_out), 32'd0);
    chk("midrst_grant", 32'(grant_out), 32'd0);
    chk("midrst_addr", 32'(bram_addr_out), 32'd0);
    chk("midrst_busy", 32'(busy_out), 32'd0);
    @(posedge pixel_clk_in);
    @(negedge pixel_clk_in);
    rst_n_in = 1'b1;
    model_reset();
    cyc = 0;
    check_and_log();
    repeat (6) tick();
    anydv = 0;
    for (int c = 0; c <= 6; c++) anydv += (log_dv[c] != '0) ? 1 : 0;
    chk("midrst_no_dv", 32'(anydv), 32'd0);
    contention();
    drain(4);

    // fairness under continuous requests
    drop_mask = '0; c0 = 0; c1 = 0;
    req_in = 2'b11; addr_in[0] = rand_addr() % 10'd576; addr_in[1] = rand_addr() % 10'd576;
    repeat (100) begin
      tick();
      c0 += int'(log_grant[cyc][0]);
      c1 += int'(log_grant[cyc][1]);
    end
    chk("fair_diff", 32'((c0 > c1 ? c0 - c1 : c1 - c0) <= 1), 32'd1);
    chk("fair_total", 32'((c0 + c1) >= 38), 32'd1);
    drain(8);

    // random traffic
    drop_mask = '0;
    repeat (400) begin
      for (int i = 0; i < NR; i++) begin
        if (req_in[i] && exp_dv[cyc][i]) begin
          if ($urandom_range(1, 0) == 1) req_in[i] = 1'b0;
          else addr_in[i] = rand_addr();
        end else if (!req_in[i] && $urandom_range(3, 0) == 0) begin
          req_in[i]  = 1'b1;
          addr_in[i] = rand_addr();
        end
      end
      tick();
    end
    drain(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
